// File: rtl/shreg_tx_scheduler.sv
// Round-robin scheduler sharing one PISO shift register among NREQ requesters.
// Granted word is shifted out LSB first with so_valid framing and a done pulse.
module shreg_tx_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  so,
    output logic                  so_valid,
    output logic [IDW-1:0]        sel_id,
    output logic                  busy,
    output logic                  done
);
    localparam int          CW     = $clog2(WIDTH);
    localparam int unsigned NREQ_U = NREQ;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   sel_q, sel_d;

    logic [IDW-1:0]   cand;
    logic [IDW-1:0]   winner;
    logic             found;
    logic [WIDTH-1:0] win_word;

    // Search starts one past the last grant and wraps, so the previous winner is lowest priority.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        cand     = '0;
        win_word = '0;
        for (int unsigned off = 1; off <= NREQ_U; off++) begin
            cand = IDW'((32'(ptr_q) + off) % NREQ_U);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            if (winner == IDW'(i)) begin
                win_word = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        req_ready = '0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready = NREQ'(1) << winner;
                    shreg_d   = win_word;
                    sel_d     = winner;
                    ptr_d     = winner;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                sel_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            ptr_q   <= IDW'(NREQ - 1);
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
        end
    end

    // Outputs decode registered state only, so reset clears them without waiting for a clock.
    assign so       = (state_q == SHIFT) & shreg_q[0];
    assign so_valid = (state_q == SHIFT);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign sel_id   = sel_q;

endmodule

// File: tb/tb_shreg_tx_scheduler.sv
// Directed self-checking bench for shreg_tx_scheduler (NREQ=4, WIDTH=4).
module tb_shreg_tx_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic        so;
    logic        so_valid;
    logic [1:0]  sel_id;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    shreg_tx_scheduler #(.NREQ(4), .WIDTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .so        (so),
        .so_valid  (so_valid),
        .sel_id    (sel_id),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in IDLE at posedge+1 with inputs set; returns in IDLE at posedge+1.
    // opt[0]: drop req_valid after accept, opt[1]: overwrite req_data during SHIFT.
    task automatic frame(input int w, input logic [3:0] word, input logic [1:0] opt, output int acc);
        #1;
        check("ready_grant", 32'(req_ready), 32'(1) << w);
        check("busy_idle", 32'(busy), 0);
        tick();
        acc = cyc;
        if (opt[0]) req_valid = '0;
        if (opt[1]) req_data = '1;
        for (int b = 0; b < 4; b++) begin
            check("so_valid", 32'(so_valid), 1);
            check("so_bit", 32'(so), 32'(word[b]));
            check("sel_shift", 32'(sel_id), 32'(w));
            check("ready_held", 32'(req_ready), 0);
            check("busy_shift", 32'(busy), 1);
            check("done_shift", 32'(done), 0);
            tick();
        end
        check("done_pulse", 32'(done), 1);
        check("done_so_valid", 32'(so_valid), 0);
        check("done_so", 32'(so), 0);
        check("done_sel", 32'(sel_id), 32'(w));
        check("done_busy", 32'(busy), 1);
        check("done_ready", 32'(req_ready), 0);
        tick();
        check("idle_done", 32'(done), 0);
        check("idle_busy", 32'(busy), 0);
        check("idle_sel", 32'(sel_id), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int prev;
        int exp_w [5];
        logic [3:0] exp_word [5];

        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        repeat (2) tick();
        check("rst_so", 32'(so), 0);
        check("rst_so_valid", 32'(so_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_sel", 32'(sel_id), 0);
        check("rst_ready", 32'(req_ready), 0);
        reset = 1'b0;
        tick();

        // 1: single word, valid for one accept cycle only
        req_valid = 4'b0001;
        req_data  = 16'h000B;
        frame(0, 4'hB, 2'b01, acc);
        check("t1_ready_after", 32'(req_ready), 0);

        // 2: round-robin from reset pointer, 6-cycle accept period
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick();
        req_valid = 4'b1111;
        req_data  = 16'h8421;
        exp_w    = '{0, 1, 2, 3, 0};
        exp_word = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
        prev = 0;
        for (int g = 0; g < 5; g++) begin
            frame(exp_w[g], exp_word[g], 2'b00, acc);
            if (g > 0) check("rr_period", 32'(acc - prev), 6);
            prev = acc;
        end

        // 3: pointer to 2, then 0/1 requesting: wrap to 0, then 1, then 0
        req_valid = 4'b0100;
        req_data  = 16'h0500;
        frame(2, 4'h5, 2'b00, acc);
        req_valid = 4'b0011;
        req_data  = 16'h0021;
        frame(0, 4'h1, 2'b00, acc);
        frame(1, 4'h2, 2'b00, acc);
        frame(0, 4'h1, 2'b00, acc);

        // 4: data changes during SHIFT do not affect word in flight
        req_valid = 4'b0010;
        req_data  = 16'h0060;
        frame(1, 4'h6, 2'b11, acc);

        // 5: reset in second SHIFT cycle aborts the word
        req_valid = 4'b0001;
        req_data  = 16'h000F;
        #1;
        check("t5_ready", 32'(req_ready), 1);
        tick();
        check("t5_so1", 32'(so), 1);
        req_valid = '0;
        tick();
        check("t5_so2", 32'(so_valid), 1);
        reset = 1'b1;
        #1;
        check("abort_so", 32'(so), 0);
        check("abort_so_valid", 32'(so_valid), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("abort_no_done", 32'(done), 0);
            check("abort_idle", 32'(so_valid), 0);
        end
        req_valid = 4'b1000;
        req_data  = 16'hA000;
        reset = 1'b0;
        frame(3, 4'hA, 2'b01, acc);
        reset = 1'b1;
        req_valid = 4'b1001;
        req_data  = 16'h5003;
        tick();
        reset = 1'b0;
        frame(0, 4'h3, 2'b01, acc);

        // 6: idle stability
        req_valid = '0;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("idle_ready", 32'(req_ready), 0);
            check("idle_so_valid", 32'(so_valid), 0);
            check("idle_busy20", 32'(busy), 0);
            check("idle_done20", 32'(done), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
